// File: rtl/coef_loader.sv
// Coefficient RAM loader: assembles 16-bit coefficients from a byte stream and writes them out.
// Optional checksum trailer, enabled by defining COEF_CHECKSUM_EN.
module coef_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int N_COEFS    = 64
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  output logic                  we_out,
  output logic [ADDR_WIDTH-1:0] waddr_out,
  output logic [15:0]           wdata_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  err_out
);

`ifdef COEF_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, GET_HI, GET_LO, WRITE, GET_CK_HI, GET_CK_LO, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, GET_HI, GET_LO, WRITE, DONE
  } state_t;
`endif

  localparam logic [ADDR_WIDTH:0] N_LIM = (ADDR_WIDTH+1)'(N_COEFS);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [15:0]           wdata;
  logic                  last;
  logic                  accept;

  // Counter compare is one bit wider so N_COEFS == 2**ADDR_WIDTH never wraps.
  assign cnt_inc   = {1'b0, cnt} + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last      = (cnt_inc >= N_LIM);
  assign waddr_out = cnt;
  assign wdata_out = wdata;

  always_comb begin
    state_nxt      = state;
    byte_ready_out = 1'b0;
    we_out         = 1'b0;
    busy_out       = 1'b0;
    done_out       = 1'b0;
    case (state)
      IDLE: ;
      GET_HI: begin
        byte_ready_out = 1'b1;
        busy_out       = 1'b1;
        if (byte_valid_in) state_nxt = GET_LO;
      end
      GET_LO: begin
        byte_ready_out = 1'b1;
        busy_out       = 1'b1;
        if (byte_valid_in) state_nxt = WRITE;
      end
      WRITE: begin
        busy_out = 1'b1;
        we_out   = !start_in;
`ifdef COEF_CHECKSUM_EN
        state_nxt = last ? GET_CK_HI : GET_HI;
`else
        state_nxt = last ? DONE : GET_HI;
`endif
      end
`ifdef COEF_CHECKSUM_EN
      GET_CK_HI: begin
        byte_ready_out = 1'b1;
        busy_out       = 1'b1;
        if (byte_valid_in) state_nxt = GET_CK_LO;
      end
      GET_CK_LO: begin
        byte_ready_out = 1'b1;
        busy_out       = 1'b1;
        if (byte_valid_in) state_nxt = DONE;
      end
`endif
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // A start pulse in any state (including mid-load abort) restarts at address 0.
    if (start_in) state_nxt = GET_HI;
  end

  assign accept = byte_ready_out & byte_valid_in;

`ifdef COEF_CHECKSUM_EN
  logic [15:0] sum;
  logic [7:0]  ck_hi;
  logic        err;

  assign err_out = err;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      wdata <= '0;
      sum   <= '0;
      ck_hi <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_in) begin
        cnt <= '0;
        sum <= '0;
        err <= 1'b0;
      end else begin
        case (state)
          GET_HI:    if (accept) wdata[15:8] <= byte_in;
          GET_LO:    if (accept) wdata[7:0]  <= byte_in;
          WRITE: begin
            sum <= sum + wdata;
            if (!last) cnt <= cnt_inc[ADDR_WIDTH-1:0];
          end
          GET_CK_HI: if (accept) ck_hi <= byte_in;
          GET_CK_LO: if (accept) err <= (sum != {ck_hi, byte_in});
          default: ;
        endcase
      end
    end
  end
`else
  assign err_out = 1'b0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      cnt   <= '0;
      wdata <= '0;
    end else begin
      state <= state_nxt;
      if (start_in) begin
        cnt <= '0;
      end else begin
        case (state)
          GET_HI: if (accept) wdata[15:8] <= byte_in;
          GET_LO: if (accept) wdata[7:0]  <= byte_in;
          WRITE:  if (!last) cnt <= cnt_inc[ADDR_WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_coef_loader.sv
// Directed bench for coef_loader: a 4-coefficient instance (a) and a full-range
// 8-coefficient instance (b, ADDR_WIDTH=3).
module tb_coef_loader;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic        rst_in;
  logic [7:0]  byte_in;
  logic        start_a, start_b, valid_a, valid_b;
  logic        ready_a, we_a, busy_a, done_a, err_a;
  logic [7:0]  waddr_a;
  logic [15:0] wdata_a;
  logic        ready_b, we_b, busy_b, done_b, err_b;
  logic [2:0]  waddr_b;
  logic [15:0] wdata_b;

  coef_loader #(.ADDR_WIDTH(8), .N_COEFS(4)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_a), .byte_in(byte_in),
    .byte_valid_in(valid_a), .byte_ready_out(ready_a), .we_out(we_a),
    .waddr_out(waddr_a), .wdata_out(wdata_a), .busy_out(busy_a),
    .done_out(done_a), .err_out(err_a)
  );

  coef_loader #(.ADDR_WIDTH(3), .N_COEFS(8)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b), .byte_in(byte_in),
    .byte_valid_in(valid_b), .byte_ready_out(ready_b), .we_out(we_b),
    .waddr_out(waddr_b), .wdata_out(wdata_b), .busy_out(busy_b),
    .done_out(done_b), .err_out(err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int wr_a  = 0;
  int wr_b  = 0;

  always @(negedge clk_in) begin
    if (we_a) wr_a++;
    if (we_b) wr_b++;
  end

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [7:0]  addr;
    logic [15:0] data;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks begin and end 1 time unit after a rising edge.
  task automatic pulse_start(input bit w);
    if (w) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk_in); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd, input bit w);
    int n;
    bit acc;
    if (rnd) begin
      while ($urandom_range(1, 0) == 1) begin
        valid_a = 1'b0; valid_b = 1'b0;
        @(posedge clk_in); #1;
      end
    end
    byte_in = b;
    if (w) valid_b = 1'b1; else valid_a = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      @(negedge clk_in);
      acc = w ? ready_b : ready_a;
      @(posedge clk_in); #1;
      n++;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    if (!acc) chk("handshake_timeout", 32'(acc), 32'd1);
  endtask

  // Write must appear in the cycle right after the low-byte handshake.
  task automatic load_coef(input logic [7:0] hi, input logic [7:0] lo,
                           input logic [7:0] exp_addr, input bit rnd, input bit w);
    send_byte(hi, rnd, w);
    send_byte(lo, rnd, w);
    @(negedge clk_in);
    if (w) begin
      chk("b_we", 32'(we_b), 32'd1);
      chk("b_waddr", 32'(waddr_b), 32'(exp_addr));
      chk("b_wdata", 32'(wdata_b), {16'h0, hi, lo});
    end else begin
      chk("a_we", 32'(we_a), 32'd1);
      chk("a_waddr", 32'(waddr_a), 32'(exp_addr));
      chk("a_wdata", 32'(wdata_a), {16'h0, hi, lo});
    end
    @(posedge clk_in); #1;
  endtask

  task automatic finish_load(input logic [15:0] sum, input bit bad, input bit w);
`ifdef COEF_CHECKSUM_EN
    send_byte(sum[15:8], 1'b0, w);
    send_byte(sum[7:0] ^ {7'h0, bad}, 1'b0, w);
`endif
    @(negedge clk_in);
    chk("done_pulse", 32'(w ? done_b : done_a), 32'd1);
    chk("busy_on_done", 32'(w ? busy_b : busy_a), 32'd0);
    chk("err_on_done", 32'(w ? err_b : err_a), 32'(bad));
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("done_cleared", 32'(w ? done_b : done_a), 32'd0);
    chk("busy_after", 32'(w ? busy_b : busy_a), 32'd0);
    @(posedge clk_in); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] sum;
    int          w0;
    logic [7:0]  h, l;

    tbl[0] = '{8'h12, 8'h34, 8'd0, 16'h1234};
    tbl[1] = '{8'hFF, 8'hFE, 8'd1, 16'hFFFE};
    tbl[2] = '{8'h00, 8'h01, 8'd2, 16'h0001};
    tbl[3] = '{8'h80, 8'h00, 8'd3, 16'h8000};

    rst_in = 1'b1; byte_in = '0;
    start_a = 1'b0; start_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    #12;
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_we",    32'(we_a),    32'd0);
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_err",   32'(err_a),   32'd0);
    chk("rst_waddr", 32'(waddr_a), 32'd0);
    chk("rst_wdata", 32'(wdata_a), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(posedge clk_in); #1;

    // Basic load, then the same load with random valid gaps.
    for (int pass = 0; pass < 2; pass++) begin
      w0 = wr_a;
      pulse_start(1'b0);
      chk("busy_after_start", 32'(busy_a), 32'd1);
      sum = '0;
      for (int i = 0; i < 4; i++) begin
        load_coef(tbl[i].hi, tbl[i].lo, tbl[i].addr, pass == 1, 1'b0);
        sum = sum + tbl[i].data;
      end
      finish_load(sum, 1'b0, 1'b0);
      chk("write_count", 32'(wr_a - w0), 32'd4);
    end

`ifdef COEF_CHECKSUM_EN
    pulse_start(1'b0);
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      load_coef(tbl[i].hi, tbl[i].lo, tbl[i].addr, 1'b0, 1'b0);
      sum = sum + tbl[i].data;
    end
    finish_load(sum, 1'b1, 1'b0);
    chk("err_sticky", 32'(err_a), 32'd1);
    pulse_start(1'b0);
    chk("err_cleared_by_start", 32'(err_a), 32'd0);
`endif

    // Abort in GET_LO at address 2, then abort during a WRITE cycle.
    w0 = wr_a;
    pulse_start(1'b0);
    load_coef(tbl[0].hi, tbl[0].lo, 8'd0, 1'b0, 1'b0);
    load_coef(tbl[1].hi, tbl[1].lo, 8'd1, 1'b0, 1'b0);
    send_byte(tbl[2].hi, 1'b0, 1'b0);
    pulse_start(1'b0);
    load_coef(tbl[2].hi, tbl[2].lo, 8'd0, 1'b0, 1'b0);
    send_byte(tbl[3].hi, 1'b0, 1'b0);
    send_byte(tbl[3].lo, 1'b0, 1'b0);
    start_a = 1'b1;
    @(negedge clk_in);
    chk("abort_in_write_we", 32'(we_a), 32'd0);
    @(posedge clk_in); #1;
    start_a = 1'b0;
    sum = '0;
    for (int i = 0; i < 4; i++) begin
      load_coef(tbl[i].hi, tbl[i].lo, tbl[i].addr, 1'b0, 1'b0);
      sum = sum + tbl[i].data;
    end
    finish_load(sum, 1'b0, 1'b0);
    chk("abort_write_count", 32'(wr_a - w0), 32'd7);

    // Asynchronous reset in the middle of a byte transfer.
    pulse_start(1'b0);
    send_byte(tbl[0].hi, 1'b0, 1'b0);
    byte_in = tbl[0].lo;
    valid_a = 1'b1;
    #2 rst_in = 1'b1;
    #1;
    chk("arst_ready", 32'(ready_a), 32'd0);
    chk("arst_we",    32'(we_a),    32'd0);
    chk("arst_busy",  32'(busy_a),  32'd0);
    chk("arst_done",  32'(done_a),  32'd0);
    chk("arst_err",   32'(err_a),   32'd0);
    chk("arst_waddr", 32'(waddr_a), 32'd0);
    chk("arst_wdata", 32'(wdata_a), 32'd0);
    w0 = wr_a;
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    repeat (4) @(posedge clk_in);
    #1;
    chk("no_write_after_reset", 32'(wr_a - w0), 32'd0);
    chk("idle_after_reset", 32'(busy_a), 32'd0);
    valid_a = 1'b0;

    // Full-range load on instance b: last address is all ones, no wrap.
    w0 = wr_b;
    pulse_start(1'b1);
    sum = '0;
    for (int i = 0; i < 8; i++) begin
      h = 8'(i * 17 + 3);
      l = 8'(8'hF0 ^ i);
      load_coef(h, l, 8'(i), (i % 2) == 1, 1'b1);
      sum = sum + {h, l};
    end
    finish_load(sum, 1'b0, 1'b1);
    chk("full_write_count", 32'(wr_b - w0), 32'd8);
    chk("full_no_wrap", 32'(waddr_b), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
